// File: rtl/write_bus_pkg.sv
// Definitions shared by the peripheral read and write paths: address
// decode fields, peripheral select codes and the default timer prescale.
package write_bus_pkg;

  localparam int unsigned REGION_BIT       = 8;
  localparam int unsigned SEL_LSB          = 2;
  localparam int unsigned SEL_W            = 3;
  localparam int unsigned TICK_DIV_DEFAULT = 10000;

  typedef enum logic [2:0] {
    PER_ADC_CTRL  = 3'd0,
    PER_ADC_DATA  = 3'd1,
    PER_TECLADO   = 3'd2,
    PER_SIETE_SEG = 3'd3,
    PER_LEDS      = 3'd4,
    PER_SWITCHES  = 3'd5,
    PER_TIMER     = 3'd6,
    PER_UNUSED    = 3'd7
  } per_sel_e;

endpackage

// File: rtl/write_bus_timer.sv
// Countdown timer: free-running prescaler issuing ticks every TICK_DIV cycles,
// a 31-bit count that decrements per tick and a sticky expired flag.
module timer_countdown
  import write_bus_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [30:0] load_value_i,
  output logic [31:0] timer_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [30:0]   cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          tick_s;

  assign tick_s  = (pre_q == PRE_TC);
  assign timer_o = {flag_q, cnt_q};

  // Next state: a load overrides a coincident tick; count 0 saturates.
  always_comb begin
    pre_d  = tick_s ? {PW{1'b0}} : (pre_q + PW'(1'b1));
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (load_i) begin
      pre_d  = {PW{1'b0}};
      cnt_d  = load_value_i;
      flag_d = 1'b0;
    end else if (tick_s && (cnt_q != 31'd0)) begin
      cnt_d = cnt_q - 31'd1;
      if (cnt_q == 31'd1) begin
        flag_d = 1'b1;
      end else begin
        flag_d = flag_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q  <= {PW{1'b0}};
      cnt_q  <= 31'd0;
      flag_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/write_bus.sv
// CPU store decode: RAM write-enable gating, writable peripheral registers,
// one-cycle ADC-start / keypad-ack strobes and the countdown timer.
module write_bus
  import write_bus_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addrs,
  input  logic [31:0] data_out,
  input  logic        we,
  output logic        RAM_we,
  output logic [31:0] ADC_control,
  output logic        adc_start,
  output logic        teclado_ack,
  output logic [31:0] siete_segmentos,
  output logic [31:0] LEDs,
  output logic [31:0] Timer
);

  logic [31:0] adc_ctrl_q, adc_ctrl_d;
  logic [31:0] seg_q, seg_d;
  logic [31:0] led_q, led_d;
  logic        adc_start_q, adc_start_d;
  logic        ack_q, ack_d;
  logic        pwr_s;
  logic        tmr_load_s;
  per_sel_e    sel_s;

  assign RAM_we = we & ~addrs[REGION_BIT];
  assign pwr_s  = we & addrs[REGION_BIT];
  assign sel_s  = per_sel_e'(addrs[SEL_LSB +: SEL_W]);

  // Store decode; strobes default low so each store yields exactly one pulse.
  always_comb begin
    adc_ctrl_d  = adc_ctrl_q;
    seg_d       = seg_q;
    led_d       = led_q;
    adc_start_d = 1'b0;
    ack_d       = 1'b0;
    tmr_load_s  = 1'b0;
    if (pwr_s) begin
      case (sel_s)
        PER_ADC_CTRL: begin
          adc_ctrl_d  = {data_out[31:1], 1'b0};
          adc_start_d = data_out[0];
        end
        PER_TECLADO:   ack_d      = 1'b1;
        PER_SIETE_SEG: seg_d      = data_out;
        PER_LEDS:      led_d      = data_out;
        PER_TIMER:     tmr_load_s = 1'b1;
        default:       tmr_load_s = 1'b0;
      endcase
    end else begin
      tmr_load_s = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_ctrl_q  <= 32'd0;
      seg_q       <= 32'd0;
      led_q       <= 32'd0;
      adc_start_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      adc_ctrl_q  <= adc_ctrl_d;
      seg_q       <= seg_d;
      led_q       <= led_d;
      adc_start_q <= adc_start_d;
      ack_q       <= ack_d;
    end
  end

  timer_countdown #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (tmr_load_s),
    .load_value_i (data_out[30:0]),
    .timer_o      (Timer)
  );

  assign ADC_control     = adc_ctrl_q;
  assign siete_segmentos = seg_q;
  assign LEDs            = led_q;
  assign adc_start       = adc_start_q;
  assign teclado_ack     = ack_q;

endmodule

// File: tb/tb_write_bus.sv
// Directed bench for write_bus: expectations are queued as stimulus is driven
// and popped when the corresponding output is sampled.
module tb_write_bus;

  logic        clk;
  logic        rst_n;
  logic [31:0] addrs;
  logic [31:0] data_out;
  logic        we;
  logic        RAM_we;
  logic [31:0] ADC_control;
  logic        adc_start;
  logic        teclado_ack;
  logic [31:0] siete_segmentos;
  logic [31:0] LEDs;
  logic [31:0] Timer;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  write_bus #(.TICK_DIV(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .addrs           (addrs),
    .data_out        (data_out),
    .we              (we),
    .RAM_we          (RAM_we),
    .ADC_control     (ADC_control),
    .adc_start       (adc_start),
    .teclado_ack     (teclado_ack),
    .siete_segmentos (siete_segmentos),
    .LEDs            (LEDs),
    .Timer           (Timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] v);
    sb_item_t it;
    it.tag = tag;
    it.exp = v;
    sb_q.push_back(it);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_item_t it;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h expected <none>", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addrs    = a;
    data_out = d;
    we       = 1'b1;
    step();
    we       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; addrs = 32'h0; data_out = 32'h0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Fill every register, then reset mid-cycle while the keypad ack is high
    store(32'h110, 32'h0000_00AA);
    push("prefill_leds", 32'hAA); chk(LEDs);
    store(32'h10C, 32'h0000_1234);
    store(32'h100, 32'h0000_0009);
    push("prefill_adc_start", 32'd1); chk({31'd0, adc_start});
    store(32'h118, 32'h0000_0007);
    push("prefill_timer", 32'd7); chk(Timer);
    store(32'h108, 32'h0);
    push("prefill_ack", 32'd1); chk({31'd0, teclado_ack});
    #2 rst_n = 1'b0;
    #1;
    push("rst_leds", 32'h0);      chk(LEDs);
    push("rst_seg", 32'h0);       chk(siete_segmentos);
    push("rst_adc_ctrl", 32'h0);  chk(ADC_control);
    push("rst_timer", 32'h0);     chk(Timer);
    push("rst_ack", 32'h0);       chk({31'd0, teclado_ack});
    push("rst_adc_start", 32'h0); chk({31'd0, adc_start});
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      push("post_rst_ack", 32'h0); chk({31'd0, teclado_ack});
    end

    // RAM vs peripheral region
    addrs = 32'h000; data_out = 32'h55; we = 1'b1;
    #1;
    push("ram_we_ram", 32'd1); chk({31'd0, RAM_we});
    step(); we = 1'b0;
    push("leds_after_ram", 32'h0); chk(LEDs);
    addrs = 32'h110; we = 1'b1;
    #1;
    push("ram_we_periph", 32'd0); chk({31'd0, RAM_we});
    step(); we = 1'b0;
    push("leds_write", 32'h55); chk(LEDs);
    store(32'h10C, 32'hDEAD_BEEF);
    push("seg_write", 32'hDEAD_BEEF); chk(siete_segmentos);

    // ADC control and start strobe
    store(32'h100, 32'h0000_0003);
    push("adc_ctrl", 32'h2);     chk(ADC_control);
    push("adc_start_hi", 32'd1); chk({31'd0, adc_start});
    step();
    push("adc_start_lo", 32'd0); chk({31'd0, adc_start});
    store(32'h100, 32'h0000_0002);
    push("adc_ctrl_2", 32'h2);     chk(ADC_control);
    push("adc_start_none", 32'd0); chk({31'd0, adc_start});

    // Read-only / unused selects are ignored
    begin
      logic [31:0] ign_addr [3];
      ign_addr[0] = 32'h104; ign_addr[1] = 32'h114; ign_addr[2] = 32'h11C;
      for (int i = 0; i < 3; i++) begin
        addrs = ign_addr[i]; data_out = 32'hFFFF_FFFF; we = 1'b1;
        #1;
        push("ign_ram_we", 32'd0); chk({31'd0, RAM_we});
        step(); we = 1'b0;
        push("ign_leds", 32'h55);        chk(LEDs);
        push("ign_seg", 32'hDEAD_BEEF);  chk(siete_segmentos);
        push("ign_adc", 32'h2);          chk(ADC_control);
        push("ign_strobes", 32'd0);      chk({30'd0, adc_start, teclado_ack});
      end
    end

    // Back-to-back keypad acks from a held store
    addrs = 32'h108; data_out = 32'h0; we = 1'b1;
    step();
    push("ack_1", 32'd1); chk({31'd0, teclado_ack});
    step(); we = 1'b0;
    push("ack_2", 32'd1); chk({31'd0, teclado_ack});
    step();
    push("ack_end", 32'd0); chk({31'd0, teclado_ack});

    // Countdown: load 3, tick every 4 edges, expire after 12, then hold
    store(32'h118, 32'h0000_0003);
    push("tmr_load", 32'd3); chk(Timer);
    for (int k = 1; k <= 32; k++) begin
      logic [31:0] e;
      if (k < 4)       e = 32'd3;
      else if (k < 8)  e = 32'd2;
      else if (k < 12) e = 32'd1;
      else             e = 32'h8000_0000;
      push("tmr_count", e);
      step();
      chk(Timer);
    end

    // Reload exactly on a tick edge while expired: load wins
    repeat (3) step();
    store(32'h118, 32'h0000_0005);
    push("tmr_reload_on_tick", 32'd5); chk(Timer);
    for (int k = 1; k <= 4; k++) begin
      push("tmr_after_reload", (k < 4) ? 32'd5 : 32'd4);
      step();
      chk(Timer);
    end

    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
